// File: rtl/issue_stage.sv
// Issue stage: holds one decoded instruction, waits for its sources to clear,
// then moves the operands into the execute-side register and reserves rd.
module issue_stage #(
    parameter int REGISTER_DESCRIPTOR_WIDTH = 5,
    parameter int OPERAND_WIDTH             = 32,
    parameter int OPCODE_WIDTH              = 8,
    parameter int STALL_COUNT_WIDTH         = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_input,
    input  logic                                 dec_valid_input,
    output logic                                 dec_ready_output,
    input  logic [OPCODE_WIDTH-1:0]              dec_opcode_input,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] dec_rs0_input,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] dec_rs1_input,
    input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] dec_rd_input,
    input  logic                                 dec_writes_rd_input,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] register_operand0_output,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] register_operand1_output,
    input  logic [OPERAND_WIDTH-1:0]             operand0_data_input,
    input  logic [OPERAND_WIDTH-1:0]             operand1_data_input,
    input  logic                                 reserved_input,
    output logic                                 write_reserve_output,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] reserve_register_output,
    output logic                                 ex_valid_output,
    input  logic                                 ex_ready_input,
    output logic [OPCODE_WIDTH-1:0]              ex_opcode_output,
    output logic [OPERAND_WIDTH-1:0]             ex_operand0_output,
    output logic [OPERAND_WIDTH-1:0]             ex_operand1_output,
    output logic [REGISTER_DESCRIPTOR_WIDTH-1:0] ex_rd_output,
    output logic                                 ex_writes_rd_output,
    output logic [STALL_COUNT_WIDTH-1:0]         stall_count_output
);
    localparam int RW = REGISTER_DESCRIPTOR_WIDTH;

    logic                     hold_valid_q, hold_valid_d;
    logic [OPCODE_WIDTH-1:0]  hold_op_q, hold_op_d;
    logic [RW-1:0]            hold_rs0_q, hold_rs0_d;
    logic [RW-1:0]            hold_rs1_q, hold_rs1_d;
    logic [RW-1:0]            hold_rd_q, hold_rd_d;
    logic                     hold_wr_q, hold_wr_d;

    logic                     ex_valid_q, ex_valid_d;
    logic [OPCODE_WIDTH-1:0]  ex_op_q, ex_op_d;
    logic [OPERAND_WIDTH-1:0] ex_a_q, ex_a_d;
    logic [OPERAND_WIDTH-1:0] ex_b_q, ex_b_d;
    logic [RW-1:0]            ex_rd_q, ex_rd_d;
    logic                     ex_wr_q, ex_wr_d;

    logic [STALL_COUNT_WIDTH-1:0] stall_q, stall_d;

    logic transfer, accept;

    assign transfer = hold_valid_q & ~reserved_input & (~ex_valid_q | ex_ready_input) & ~flush_input;
    assign dec_ready_output = (~hold_valid_q | transfer) & ~flush_input;
    assign accept = dec_valid_input & dec_ready_output;

    assign register_operand0_output = hold_valid_q ? hold_rs0_q : '0;
    assign register_operand1_output = hold_valid_q ? hold_rs1_q : '0;
    assign reserve_register_output  = hold_valid_q ? hold_rd_q : '0;
    // r0 is hardwired, so it is never reserved even when the instruction "writes" it
    assign write_reserve_output     = transfer & hold_wr_q & (hold_rd_q != '0);

    assign ex_valid_output     = ex_valid_q;
    assign ex_opcode_output    = ex_op_q;
    assign ex_operand0_output  = ex_a_q;
    assign ex_operand1_output  = ex_b_q;
    assign ex_rd_output        = ex_rd_q;
    assign ex_writes_rd_output = ex_wr_q;
    assign stall_count_output  = stall_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_op_d    = hold_op_q;
        hold_rs0_d   = hold_rs0_q;
        hold_rs1_d   = hold_rs1_q;
        hold_rd_d    = hold_rd_q;
        hold_wr_d    = hold_wr_q;
        ex_valid_d   = ex_valid_q;
        ex_op_d      = ex_op_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        ex_rd_d      = ex_rd_q;
        ex_wr_d      = ex_wr_q;
        stall_d      = stall_q;

        if (flush_input) begin
            hold_valid_d = 1'b0;
            ex_valid_d   = 1'b0;
        end else begin
            if (accept) begin
                hold_valid_d = 1'b1;
                hold_op_d    = dec_opcode_input;
                hold_rs0_d   = dec_rs0_input;
                hold_rs1_d   = dec_rs1_input;
                hold_rd_d    = dec_rd_input;
                hold_wr_d    = dec_writes_rd_input;
            end else if (transfer) begin
                hold_valid_d = 1'b0;
            end

            if (transfer) begin
                ex_valid_d = 1'b1;
                ex_op_d    = hold_op_q;
                ex_a_d     = operand0_data_input;
                ex_b_d     = operand1_data_input;
                ex_rd_d    = hold_rd_q;
                ex_wr_d    = hold_wr_q;
            end else if (ex_valid_q & ex_ready_input) begin
                ex_valid_d = 1'b0;
            end
        end

        if (hold_valid_q & reserved_input & ~flush_input & ~(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_q <= 1'b0;
            hold_op_q    <= '0;
            hold_rs0_q   <= '0;
            hold_rs1_q   <= '0;
            hold_rd_q    <= '0;
            hold_wr_q    <= 1'b0;
            ex_valid_q   <= 1'b0;
            ex_op_q      <= '0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_rd_q      <= '0;
            ex_wr_q      <= 1'b0;
            stall_q      <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_op_q    <= hold_op_d;
            hold_rs0_q   <= hold_rs0_d;
            hold_rs1_q   <= hold_rs1_d;
            hold_rd_q    <= hold_rd_d;
            hold_wr_q    <= hold_wr_d;
            ex_valid_q   <= ex_valid_d;
            ex_op_q      <= ex_op_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_rd_q      <= ex_rd_d;
            ex_wr_q      <= ex_wr_d;
            stall_q      <= stall_d;
        end
    end
endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: directed timing cases, then a random program run
// against an in-order architectural model with a reservation-tracking regfile.
module tb_issue_stage;
    localparam int SCW = 12;
    localparam logic [SCW-1:0] SAT = '1;

    logic clk = 0, rst = 0, flush = 0;
    logic dec_valid = 0, dec_ready;
    logic [7:0] dec_op = 0;
    logic [4:0] dec_rs0 = 0, dec_rs1 = 0, dec_rd = 0;
    logic dec_w = 0;
    logic [4:0] desc0, desc1, rsv_reg, ex_rd;
    logic [31:0] d0, d1, ex_a, ex_b;
    logic reserved, write_reserve, ex_valid, ex_w;
    logic ex_ready = 0;
    logic [7:0] ex_op;
    logic [SCW-1:0] stall_count;

    // directed-mode drive vs. regfile-model drive
    bit auto = 0;
    logic rsv_dir = 0;
    logic [31:0] d0_dir = 0, d1_dir = 0;

    logic [31:0] regs[32];
    logic [31:0] arch[32];
    int cnt[32];

    typedef struct { logic [7:0] op; logic [4:0] rd; logic w; logic [31:0] a; logic [31:0] b; } exp_t;
    typedef struct { logic [4:0] rd; logic [31:0] v; int due; } wb_t;
    exp_t expq[$];
    wb_t wbq[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, stall_exp = 0, exp_res = 0, obs_res = 0;
    bit acc = 0, rsv_evt = 0;
    logic [4:0] rsv_r = 0;

    issue_stage #(.STALL_COUNT_WIDTH(SCW)) dut (
        .clk(clk), .rst(rst), .flush_input(flush),
        .dec_valid_input(dec_valid), .dec_ready_output(dec_ready),
        .dec_opcode_input(dec_op), .dec_rs0_input(dec_rs0), .dec_rs1_input(dec_rs1),
        .dec_rd_input(dec_rd), .dec_writes_rd_input(dec_w),
        .register_operand0_output(desc0), .register_operand1_output(desc1),
        .operand0_data_input(d0), .operand1_data_input(d1),
        .reserved_input(reserved), .write_reserve_output(write_reserve),
        .reserve_register_output(rsv_reg),
        .ex_valid_output(ex_valid), .ex_ready_input(ex_ready),
        .ex_opcode_output(ex_op), .ex_operand0_output(ex_a), .ex_operand1_output(ex_b),
        .ex_rd_output(ex_rd), .ex_writes_rd_output(ex_w),
        .stall_count_output(stall_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        reserved = auto ? ((desc0 != 0 && cnt[desc0] != 0) || (desc1 != 0 && cnt[desc1] != 0)) : rsv_dir;
        d0 = auto ? regs[desc0] : d0_dir;
        d1 = auto ? regs[desc1] : d1_dir;
    end

    function automatic logic [31:0] res(logic [7:0] op, logic [31:0] a, logic [31:0] b);
        return a + b + {24'd0, op};
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // model sampling and scoreboard compare, away from the active edge
    always @(negedge clk) if (auto) begin
        acc = dec_valid && dec_ready;
        if (acc) begin
            exp_t e;
            e.op = dec_op; e.rd = dec_rd; e.w = dec_w;
            e.a = arch[dec_rs0]; e.b = arch[dec_rs1];
            expq.push_back(e);
            if (dec_w && dec_rd != 0) begin
                arch[dec_rd] = res(dec_op, e.a, e.b);
                exp_res++;
            end
        end
        if (write_reserve) begin
            obs_res++; rsv_evt = 1; rsv_r = rsv_reg;
        end
        if (reserved) stall_exp++;
        if (ex_valid && ex_ready) begin
            if (expq.size() == 0) chk("ex_unexpected", 1, 0);
            else begin
                exp_t e;
                e = expq.pop_front();
                chk("ex_opcode", ex_op, e.op);
                chk("ex_rd", ex_rd, e.rd);
                chk("ex_writes_rd", ex_w, e.w);
                chk("ex_operand0", ex_a, e.a);
                chk("ex_operand1", ex_b, e.b);
                if (e.w && e.rd != 0)
                    wbq.push_back('{rd: e.rd, v: res(e.op, e.a, e.b), due: cyc + int'($urandom_range(1, 4))});
            end
        end
    end

    // regfile model: reservations set and write-backs land at the clock edge
    always @(posedge clk) if (auto) begin
        bit inc, dec;
        logic [4:0] dr;
        cyc++;
        inc = rsv_evt; rsv_evt = 0;
        dec = 0; dr = 0;
        if (wbq.size() != 0 && wbq[0].due <= cyc) begin
            wb_t w;
            w = wbq.pop_front();
            dec = 1; dr = w.rd;
            regs[w.rd] <= w.v;
        end
        if (!(inc && dec && rsv_r == dr)) begin
            if (inc) cnt[rsv_r] <= cnt[rsv_r] + 1;
            if (dec) cnt[dr] <= cnt[dr] - 1;
        end
    end

    task automatic present(logic [7:0] op, logic [4:0] s0, logic [4:0] s1, logic [4:0] d, logic w);
        dec_valid = 1; dec_op = op; dec_rs0 = s0; dec_rs1 = s1; dec_rd = d; dec_w = w;
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 32; i++) begin cnt[i] = 0; regs[i] = 0; arch[i] = 0; end
        #2;
        chk("rst_dec_ready", dec_ready, 1);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_write_reserve", write_reserve, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_desc0", desc0, 0);
        chk("rst_ex_operand0", ex_a, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        // first instruction latency
        present(8'hA5, 1, 2, 3, 1); d0_dir = 32'h11; d1_dir = 32'h22; ex_ready = 1;
        @(negedge clk); chk("c0_dec_ready", dec_ready, 1);
        @(posedge clk); #1 dec_valid = 0;
        @(negedge clk);
        chk("c1_write_reserve", write_reserve, 1);
        chk("c1_reserve_reg", rsv_reg, 3);
        chk("c1_desc0", desc0, 1);
        chk("c1_desc1", desc1, 2);
        chk("c1_ex_valid", ex_valid, 0);
        @(negedge clk);
        chk("c2_ex_valid", ex_valid, 1);
        chk("c2_operand0", ex_a, 32'h11);
        chk("c2_operand1", ex_b, 32'h22);
        chk("c2_rd", ex_rd, 3);
        chk("c2_opcode", ex_op, 8'hA5);
        chk("c2_write_reserve", write_reserve, 0);

        // execute back-pressure in FULL state
        ex_ready = 0; present(8'h3C, 4, 6, 5, 1); d0_dir = 32'h33; d1_dir = 32'h44;
        @(posedge clk); #1 dec_valid = 0;
        @(negedge clk);
        chk("bp_dec_ready", dec_ready, 0);
        chk("bp_write_reserve", write_reserve, 0);
        chk("bp_operand0_stable", ex_a, 32'h11);
        @(negedge clk);
        chk("bp_operand0_stable2", ex_a, 32'h11);
        chk("bp_ex_valid", ex_valid, 1);
        ex_ready = 1; #1;
        chk("bp_release_reserve", write_reserve, 1);
        chk("bp_release_reg", rsv_reg, 5);
        chk("bp_release_dec_ready", dec_ready, 1);
        @(negedge clk);
        chk("bp_operand0_new", ex_a, 32'h33);
        chk("bp_operand1_new", ex_b, 32'h44);
        chk("bp_rd_new", ex_rd, 5);

        // rd = 0 never reserves
        present(8'h77, 0, 0, 0, 1); d0_dir = 32'h55; d1_dir = 32'h66;
        @(posedge clk); #1 dec_valid = 0;
        @(negedge clk);
        chk("rd0_write_reserve", write_reserve, 0);
        @(negedge clk);
        chk("rd0_ex_valid", ex_valid, 1);
        chk("rd0_ex_rd", ex_rd, 0);
        chk("rd0_operand0", ex_a, 32'h55);

        // flush in FULL
        ex_ready = 0; present(8'h01, 1, 2, 7, 1);
        @(posedge clk); #1 dec_valid = 0; flush = 1; ex_ready = 1;
        @(negedge clk);
        chk("fl_write_reserve", write_reserve, 0);
        chk("fl_dec_ready", dec_ready, 0);
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("fl_ex_valid", ex_valid, 0);
        chk("fl_dec_ready_after", dec_ready, 1);
        chk("fl_hold_cleared", desc0, 0);

        // stall counting, saturation, reset mid-stall
        present(8'h02, 1, 2, 3, 1); rsv_dir = 1;
        @(posedge clk); #1 dec_valid = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("st_count10", stall_count, 10);
        chk("st_dec_ready", dec_ready, 0);
        chk("st_write_reserve", write_reserve, 0);
        repeat (4200) @(posedge clk);
        @(negedge clk);
        chk("st_saturate", stall_count, SAT);
        rst = 0; #1;
        chk("mr_ex_valid", ex_valid, 0);
        chk("mr_stall", stall_count, 0);
        chk("mr_write_reserve", write_reserve, 0);
        chk("mr_desc0", desc0, 0);
        chk("mr_dec_ready", dec_ready, 1);
        rsv_dir = 0;
        @(posedge clk); #1 rst = 1;

        // random program against the architectural model
        for (int i = 1; i < 32; i++) begin regs[i] = $urandom; arch[i] = regs[i]; end
        auto = 1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            ex_ready = ($urandom % 10) < 7;
            if (!dec_valid || acc)
                present(8'($urandom), 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8), 1'($urandom % 4 != 0));
            dec_valid = ($urandom % 4) != 0;
        end
        @(posedge clk); #1 dec_valid = 0; ex_ready = 1;
        waited = 0;
        while ((expq.size() != 0 || wbq.size() != 0) && waited < 500) begin
            @(posedge clk); waited++;
        end
        @(negedge clk);
        chk("drain_timeout", waited < 500, 1);
        chk("rand_pending", expq.size(), 0);
        chk("rand_reserve_pulses", obs_res, exp_res);
        chk("rand_stall_count", stall_count, (stall_exp > int'(SAT)) ? int'(SAT) : stall_exp);
        chk("rand_ex_idle", ex_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
